spi_reg_bridge: RTL and testbench

Byte-protocol decoder between the SPI_SLAVE user interface and an on-chip register bus. It parses each SPI frame (framed by the slave chip select) into a command byte plus a burst of write-data or read-data bytes. It issues single-cycle register write/read strobes and feeds read data back to SPI_SLAVE over its DIN/DIN_VLD/READY handshake.

---
 rtl/spi_reg_bridge.sv | 161 ++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// Purpose: decodes SPI_SLAVE byte stream (cmd + burst) into register bus write/read strobes,
//          and returns read data to the slave over its DIN/DIN_VLD/READY handshake.
// Latency: REG_WE 1 cycle after RX_VLD; REG_RE 2 cycles after RX_VLD; TX_DATA 2 cycles after REG_RE.
// Backpressure: TX_READY only retires the pending read byte; unretired data on the next
//               dummy byte, or bytes arriving mid-fetch, bump the saturating ERR_CNT.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   CS_N_IN                        raw chip select (async), synchronised internally
//   RX_DATA, RX_VLD                received byte from SPI_SLAVE
//   TX_DATA, TX_VLD, TX_READY      byte offered to SPI_SLAVE and its accept handshake
//   REG_ADDR, REG_WDATA, REG_WE    register write port
//   REG_RE, REG_RDATA              register read port (data valid one cycle after REG_RE)
//   BUSY, ERR_CNT                  FSM activity, saturating overrun count
module spi_reg_bridge #(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CS_N_IN,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VLD,
    output logic [7:0]        TX_DATA,
    output logic              TX_VLD,
    input  logic              TX_READY,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [7:0]        REG_WDATA,
    output logic              REG_WE,
    output logic              REG_RE,
    input  logic [7:0]        REG_RDATA,
    output logic              BUSY,
    output logic [7:0]        ERR_CNT
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        WDATA  = 3'd2,
        RFETCH = 3'd3,
        RCAPT  = 3'd4,
        RWAIT  = 3'd5
    } state_t;

    state_t             state;
    logic               cs_s1;
    logic               cs_s2;
    logic               cs_prev;
    logic [ADDR_W-1:0]  addr;
    logic               inc;
    logic               tx_pend;
    logic               re_q;

    logic               frame_start;
    logic               cs_high;
    logic               overrun;
    logic [ADDR_W-1:0]  addr_step;

    // Sync flops reset to 0 (not 1) so a frame already in progress at reset
    // release never produces a falling edge and is ignored until CS rises.
    assign frame_start = cs_prev & ~cs_s2;
    assign cs_high     = cs_s2;
    assign addr_step   = {{(ADDR_W-1){1'b0}}, inc};

    assign overrun = RX_VLD & (((state == RWAIT) & tx_pend) |
                               (state == RFETCH) | (state == RCAPT));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cs_s1     <= 1'b0;
            cs_s2     <= 1'b0;
            cs_prev   <= 1'b0;
            addr      <= '0;
            inc       <= 1'b0;
            tx_pend   <= 1'b0;
            re_q      <= 1'b0;
            TX_DATA   <= IDLE_BYTE;
            TX_VLD    <= 1'b0;
            REG_ADDR  <= '0;
            REG_WDATA <= 8'h00;
            REG_WE    <= 1'b0;
            REG_RE    <= 1'b0;
            BUSY      <= 1'b0;
            ERR_CNT   <= 8'h00;
        end else begin
            cs_s1   <= CS_N_IN;
            cs_s2   <= cs_s1;
            cs_prev <= cs_s2;

            REG_WE  <= 1'b0;
            REG_RE  <= 1'b0;
            TX_VLD  <= 1'b1;
            re_q    <= REG_RE;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= CMD;
                        BUSY  <= 1'b1;
                    end
                end
                CMD: begin
                    if (RX_VLD) begin
                        addr  <= RX_DATA[ADDR_W-1:0];
                        inc   <= RX_DATA[6];
                        state <= RX_DATA[7] ? WDATA : RFETCH;
                    end
                end
                WDATA: begin
                    if (RX_VLD) begin
                        REG_WE    <= 1'b1;
                        REG_ADDR  <= addr;
                        REG_WDATA <= RX_DATA;
                        addr      <= addr + addr_step;
                    end
                end
                RFETCH: begin
                    REG_RE   <= 1'b1;
                    REG_ADDR <= addr;
                    state    <= RCAPT;
                end
                RCAPT: begin
                    state <= RWAIT;
                end
                RWAIT: begin
                    if (RX_VLD) begin
                        addr  <= addr + addr_step;
                        state <= RFETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase

            // CS release overrides whatever the case chose; a byte arriving in
            // the same cycle has already been handled above.
            if (cs_high && state != IDLE) begin
                state <= IDLE;
                BUSY  <= 1'b0;
            end

            // REG_RDATA lags the strobe by a cycle, so the load is keyed off
            // the strobe delayed by one (re_q) rather than off the state.
            if (re_q && state != IDLE && !cs_high) begin
                TX_DATA <= REG_RDATA;
                tx_pend <= 1'b1;
            end else if (cs_high || (TX_VLD && TX_READY)) begin
                TX_DATA <= IDLE_BYTE;
                tx_pend <= 1'b0;
            end

            if (overrun && ERR_CNT != 8'hFF) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Purpose: directed self-checking bench for spi_reg_bridge.
// Latency: checks strobe/TX timing at exact cycle offsets from each stimulus byte.
// Backpressure: TX_READY is pulsed or held low to exercise retirement and overrun counting.
module tb_spi_reg_bridge;

    logic       CLK;
    logic       RST;
    logic       CS_N_IN;
    logic [7:0] RX_DATA;
    logic       RX_VLD;
    logic [7:0] TX_DATA;
    logic       TX_VLD;
    logic       TX_READY;
    logic [5:0] REG_ADDR;
    logic [7:0] REG_WDATA;
    logic       REG_WE;
    logic       REG_RE;
    logic [7:0] REG_RDATA;
    logic       BUSY;
    logic [7:0] ERR_CNT;

    int checks   = 0;
    int failures = 0;
    int re_cnt   = 0;
    int both_cnt = 0;
    logic [13:0] wq[$];

    spi_reg_bridge #(.ADDR_W(6), .IDLE_BYTE(8'hA5)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CS_N_IN   (CS_N_IN),
        .RX_DATA   (RX_DATA),
        .RX_VLD    (RX_VLD),
        .TX_DATA   (TX_DATA),
        .TX_VLD    (TX_VLD),
        .TX_READY  (TX_READY),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .REG_WE    (REG_WE),
        .REG_RE    (REG_RE),
        .REG_RDATA (REG_RDATA),
        .BUSY      (BUSY),
        .ERR_CNT   (ERR_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Register bus model and write log, sampled mid-cycle.
    always @(negedge CLK) begin
        if (REG_WE) wq.push_back({REG_ADDR, REG_WDATA});
        if (REG_RE) begin
            REG_RDATA = 8'h80 + {2'b00, REG_ADDR};
            re_cnt++;
        end
        if (REG_WE && REG_RE) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drives one RX_VLD pulse; returns at the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA = b;
        RX_VLD  = 1'b1;
        @(negedge CLK);
        RX_VLD  = 1'b0;
    endtask

    task automatic cs_fall;
        @(negedge CLK);
        CS_N_IN = 1'b0;
        idle(4);
    endtask

    task automatic cs_rise;
        @(negedge CLK);
        CS_N_IN = 1'b1;
        idle(4);
    endtask

    task automatic pulse_ready;
        TX_READY = 1'b1;
        idle(1);
        TX_READY = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        CS_N_IN   = 1'b1;
        RX_DATA   = 8'h00;
        RX_VLD    = 1'b0;
        TX_READY  = 1'b0;
        REG_RDATA = 8'h00;

        // Reset state
        idle(3);
        chk("rst_tx_vld",  TX_VLD,   0);
        chk("rst_tx_data", TX_DATA,  8'hA5);
        chk("rst_busy",    BUSY,     0);
        chk("rst_err",     ERR_CNT,  0);
        chk("rst_addr",    REG_ADDR, 0);
        RST = 1'b0;
        idle(10);
        chk("idle_tx_vld",  TX_VLD,  1);
        chk("idle_tx_data", TX_DATA, 8'hA5);
        chk("idle_busy",    BUSY,    0);
        chk("idle_strobes", wq.size() + re_cnt, 0);

        // RX_VLD with CS high is ignored
        send_byte(8'h80);
        idle(4);
        chk("idle_rx_no_we",  wq.size(), 0);
        chk("idle_rx_no_err", ERR_CNT,   0);

        // Frame-start latency: BUSY rises exactly 3 cycles after CS falls
        @(negedge CLK);
        CS_N_IN = 1'b0;
        idle(2);
        chk("busy_lat_2", BUSY, 0);
        idle(1);
        chk("busy_lat_3", BUSY, 1);

        // Write burst with increment from address 3
        send_byte(8'hC3);
        idle(4);
        send_byte(8'h11);
        chk("we_next_cycle", REG_WE,    1);
        chk("we_addr",       REG_ADDR,  3);
        chk("we_data",       REG_WDATA, 8'h11);
        idle(4);
        send_byte(8'h22);
        idle(4);
        send_byte(8'h33);
        idle(4);
        cs_rise();
        chk("wr_busy_end", BUSY, 0);
        chk("wr_count", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("wr0", wq[0], {6'd3, 8'h11});
            chk("wr1", wq[1], {6'd4, 8'h22});
            chk("wr2", wq[2], {6'd5, 8'h33});
        end
        wq.delete();

        // Address wrap: 63 then 0
        cs_fall();
        send_byte(8'hFF);
        idle(4);
        send_byte(8'hDE);
        idle(4);
        send_byte(8'hAD);
        idle(4);
        cs_rise();
        chk("wrap_count", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("wrap0", wq[0], {6'd63, 8'hDE});
            chk("wrap1", wq[1], {6'd0,  8'hAD});
        end
        wq.delete();

        // Read burst 8'h45: read, inc, addr 5; bus returns addr+0x80
        cs_fall();
        send_byte(8'h45);
        idle(1);
        chk("re_2cyc", REG_RE, 1);
        chk("re_addr", REG_ADDR, 5);
        idle(1);
        chk("rd_not_yet", TX_DATA, 8'hA5);
        idle(1);
        chk("rd0", TX_DATA, 8'h85);
        pulse_ready();
        chk("rd0_retired", TX_DATA, 8'hA5);
        send_byte(8'h00);
        idle(3);
        chk("rd1", TX_DATA, 8'h86);
        pulse_ready();
        send_byte(8'h00);
        idle(3);
        chk("rd2", TX_DATA, 8'h87);
        pulse_ready();
        send_byte(8'h00);
        idle(3);
        chk("rd3", TX_DATA, 8'h88);
        cs_rise();
        chk("rd_cs_idle", TX_DATA, 8'hA5);
        chk("rd_no_err",  ERR_CNT, 0);
        chk("rd_no_we",   wq.size(), 0);

        // Overrun with TX_READY held low, then saturation
        cs_fall();
        send_byte(8'h00);
        idle(4);
        send_byte(8'h00);
        chk("ovr_1", ERR_CNT, 1);
        idle(4);
        send_byte(8'h00);
        chk("ovr_2", ERR_CNT, 2);
        for (int i = 0; i < 300; i++) begin
            idle(2);
            send_byte(8'h00);
        end
        idle(4);
        chk("ovr_sat", ERR_CNT, 8'hFF);
        cs_rise();

        // Reset in the middle of a write frame
        cs_fall();
        send_byte(8'hC0);
        idle(4);
        send_byte(8'h01);
        idle(4);
        chk("pre_rst_we", wq.size(), 1);
        wq.delete();
        @(negedge CLK);
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
        idle(2);
        chk("mid_rst_err", ERR_CNT, 0);
        send_byte(8'h02);
        idle(4);
        send_byte(8'h03);
        idle(4);
        chk("mid_rst_busy", BUSY, 0);
        cs_rise();
        chk("mid_rst_no_we", wq.size(), 0);

        // Next frame decodes normally: no-inc write at address 10
        cs_fall();
        send_byte(8'h8A);
        idle(4);
        send_byte(8'h5A);
        idle(4);
        send_byte(8'h6B);
        idle(4);
        cs_rise();
        chk("post_rst_count", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("post_rst0", wq[0], {6'd10, 8'h5A});
            chk("post_rst1", wq[1], {6'd10, 8'h6B});
        end
        wq.delete();

        // RX_VLD coincident with synced CS rise
        cs_fall();
        send_byte(8'h81);
        idle(4);
        @(negedge CLK);
        CS_N_IN = 1'b1;
        idle(2);
        RX_DATA = 8'h77;
        RX_VLD  = 1'b1;
        idle(1);
        RX_VLD  = 1'b0;
        chk("edge_we",    REG_WE,    1);
        chk("edge_wdata", REG_WDATA, 8'h77);
        chk("edge_busy",  BUSY,      0);
        idle(4);
        chk("edge_count", wq.size(), 1);
        if (wq.size() == 1) chk("edge_wr", wq[0], {6'd1, 8'h77});

        chk("we_re_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
